// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one 8-bit ULA between the main datapath (requester 0)
// and the branch/compare unit (requester 1); the result is held until its owner accepts it.

module ula_core #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      3'b000:  y = a + b;
      3'b001:  y = a + ~b + WIDTH'(1);
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b100:  y = a ^ b;
      3'b101:  y = (a < b) ? WIDTH'(1) : '0;
      default: y = '1;
    endcase
  end
endmodule

module ula_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ReqValid,
  output logic [1:0]       ReqReady,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB1,
  input  logic [OPW-1:0]   ReqOp0,
  input  logic [OPW-1:0]   ReqOp1,
  output logic [1:0]       RespValid,
  input  logic [1:0]       RespReady,
  output logic [WIDTH-1:0] Result,
  output logic             Z,
  output logic             Busy,
  output logic [1:0]       dbg_state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic             win;
  logic             fire;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] ula_y;

  // Handshake: a request transfers on the edge where ReqValid[i] && ReqReady[i];
  // a response transfers on the edge where RespValid[i] && RespReady[i].
  // The requester that was not granted last wins a tie.
  always_comb begin
    win = 1'b0;
    if (ReqValid == 2'b11) win = ~last_grant;
    else                   win = ReqValid[1];
  end

  always_comb begin
    ReqReady = 2'b00;
    if (rst_n && state == S_IDLE && ReqValid[win]) begin
      ReqReady = win ? 2'b10 : 2'b01;
    end
  end

  assign fire      = |(ReqValid & ReqReady);
  assign Busy      = (state != S_IDLE);
  assign dbg_state = state;

  ula_core #(.WIDTH(WIDTH), .OPW(OPW)) u_ula (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (ula_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      Result     <= '0;
      Z          <= 1'b0;
      RespValid  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire) begin
            a_q        <= win ? ReqA1  : ReqA0;
            b_q        <= win ? ReqB1  : ReqB0;
            op_q       <= win ? ReqOp1 : ReqOp0;
            owner      <= win;
            last_grant <= win;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          Result    <= ula_y;
          Z         <= (ula_y == '0);
          RespValid <= owner ? 2'b10 : 2'b01;
          state     <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's acknowledge retires the result.
          if (RespReady[owner]) begin
            RespValid <= 2'b00;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_arbiter.sv
// Directed and randomized bench for ula_arbiter against a behavioural model of
// arbitration order and ULA arithmetic.

module tb_ula_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ReqValid, ReqReady, RespValid, RespReady;
  logic [7:0] ReqA0, ReqB0, ReqA1, ReqB1, Result;
  logic [2:0] ReqOp0, ReqOp1;
  logic       Z, Busy;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Model state: who was granted last, who owns the current result.
  logic       lp;
  logic       owner;
  logic [7:0] exp_res;
  logic [7:0] exp_q[$];

  ula_arbiter #(.WIDTH(8), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA0(ReqA0), .ReqB0(ReqB0), .ReqA1(ReqA1), .ReqB1(ReqB1),
    .ReqOp0(ReqOp0), .ReqOp1(ReqOp1),
    .RespValid(RespValid), .RespReady(RespReady),
    .Result(Result), .Z(Z), .Busy(Busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_ula(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    int ai = a;
    int bi = b;
    int r;
    case (op)
      3'd0:    r = (ai + bi) % 256;
      3'd1:    r = (ai - bi + 256) % 256;
      3'd2:    r = ai & bi;
      3'd3:    r = ai | bi;
      3'd4:    r = ai ^ bi;
      3'd5:    r = (ai < bi) ? 1 : 0;
      default: r = 255;
    endcase
    return 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_operands();
    ReqA0 = 8'($urandom); ReqB0 = 8'($urandom); ReqOp0 = 3'($urandom);
    ReqA1 = 8'($urandom); ReqB1 = 8'($urandom); ReqOp1 = 3'($urandom);
  endtask

  // Present a request set, complete the handshake and the EXEC cycle, check the response.
  task automatic grant(input logic [1:0] mask,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] op0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] op1);
    logic w;
    @(negedge clk);
    ReqValid = mask;
    ReqA0 = a0; ReqB0 = b0; ReqOp0 = op0;
    ReqA1 = a1; ReqB1 = b1; ReqOp1 = op1;
    #1;
    w = (mask == 2'b11) ? ~lp : mask[1];
    chk("req_ready_grant", 16'(ReqReady), w ? 16'h2 : 16'h1);
    @(posedge clk); #1;
    lp    = w;
    owner = w;
    exp_q.push_back(w ? ref_ula(a1, b1, op1) : ref_ula(a0, b0, op0));
    scramble_operands();
    chk("busy_exec", 16'(Busy), 16'h1);
    chk("resp_valid_exec", 16'(RespValid), 16'h0);
    chk("req_ready_exec", 16'(ReqReady), 16'h0);
    @(posedge clk); #1;
    exp_res = exp_q.pop_front();
    chk("resp_valid", 16'(RespValid), owner ? 16'h2 : 16'h1);
    chk("result", 16'(Result), 16'(exp_res));
    chk("zero_flag", 16'(Z), (exp_res == 8'h00) ? 16'h1 : 16'h0);
  endtask

  // Hold the response for some cycles (optionally with the wrong owner acking), then accept.
  task automatic respond(input int hold, input bit wrong);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      RespReady = wrong ? (owner ? 2'b01 : 2'b10) : 2'b00;
      @(posedge clk); #1;
      chk("hold_result", 16'(Result), 16'(exp_res));
      chk("hold_resp_valid", 16'(RespValid), owner ? 16'h2 : 16'h1);
      chk("hold_req_ready", 16'(ReqReady), 16'h0);
    end
    @(negedge clk);
    RespReady = owner ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    RespReady = 2'b00;
    chk("accept_resp_valid", 16'(RespValid), 16'h0);
    chk("accept_busy", 16'(Busy), 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; ReqValid = 2'b11; RespReady = 2'b00;
    scramble_operands();
    lp = 1'b1; owner = 1'b0; exp_res = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 16'(ReqReady), 16'h0);
    chk("rst_resp_valid", 16'(RespValid), 16'h0);
    chk("rst_result", 16'(Result), 16'h0);
    chk("rst_z", 16'(Z), 16'h0);
    chk("rst_busy", 16'(Busy), 16'h0);
    ReqValid = 2'b00;
    @(negedge clk); rst_n = 1'b1;

    // Single request, long hold
    grant(2'b01, 8'h05, 8'h03, 3'd0, 8'h00, 8'h00, 3'd0);
    chk("first_result", 16'(Result), 16'h08);
    respond(5, 1'b0);

    // Wrap and zero flag on requester 1
    grant(2'b10, 8'h00, 8'h00, 3'd0, 8'h03, 8'h03, 3'd1);
    chk("sub_zero", 16'({Result, 7'd0, Z}), 16'h0001);
    respond(0, 1'b0);
    grant(2'b10, 8'h00, 8'h00, 3'd0, 8'h00, 8'h01, 3'd1);
    chk("sub_wrap", 16'({Result, 7'd0, Z}), 16'hFF00);
    respond(1, 1'b0);
    grant(2'b10, 8'h00, 8'h00, 3'd0, 8'hFF, 8'h01, 3'd0);
    chk("add_wrap", 16'({Result, 7'd0, Z}), 16'h0001);
    respond(0, 1'b0);

    // Round-robin with both held high
    for (int i = 0; i < 4; i++) begin
      grant(2'b11, 8'hF0, 8'h3C, 3'd2, 8'hAA, 8'hFF, 3'd4);
      chk("rr_order", 16'(owner), 16'(i % 2));
      chk("rr_result", 16'(Result), (i % 2 == 0) ? 16'h30 : 16'h55);
      respond(0, 1'b0);
    end
    ReqValid = 2'b00;

    // SLT and illegal ops
    grant(2'b01, 8'h7F, 8'h80, 3'd5, 8'h00, 8'h00, 3'd0);
    chk("slt_true", 16'(Result), 16'h01);
    respond(0, 1'b0);
    grant(2'b01, 8'h80, 8'h7F, 3'd5, 8'h00, 8'h00, 3'd0);
    chk("slt_false", 16'({Result, 7'd0, Z}), 16'h0001);
    respond(0, 1'b0);
    grant(2'b01, 8'h12, 8'h34, 3'd6, 8'h00, 8'h00, 3'd0);
    chk("illegal_op", 16'({Result, 7'd0, Z}), 16'hFF00);
    respond(0, 1'b0);

    // Wrong-owner acknowledge
    grant(2'b01, 8'h21, 8'h0F, 3'd3, 8'h00, 8'h00, 3'd0);
    ReqValid = 2'b11;
    respond(3, 1'b1);
    ReqValid = 2'b00;

    // Idle with no requests
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_busy", 16'({Busy, RespValid, ReqReady}), 16'h0);
    end

    // Reset during RESP
    grant(2'b10, 8'h00, 8'h00, 3'd0, 8'h44, 8'h11, 3'd0);
    @(negedge clk);
    rst_n = 1'b0; ReqValid = 2'b11;
    #1;
    chk("midrst_resp_valid", 16'(RespValid), 16'h0);
    chk("midrst_result", 16'(Result), 16'h0);
    chk("midrst_busy", 16'(Busy), 16'h0);
    chk("midrst_req_ready", 16'(ReqReady), 16'h0);
    exp_q.delete();
    lp = 1'b1;
    @(posedge clk);
    @(negedge clk); ReqValid = 2'b00; rst_n = 1'b1;
    grant(2'b11, 8'h09, 8'h01, 3'd1, 8'h77, 8'h77, 3'd4);
    chk("post_reset_owner", 16'(owner), 16'h0);
    respond(0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      grant(2'($urandom_range(1, 3)),
            8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
      respond(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
